// File: rtl/prbs_rx_checker_pkg.sv
// Shared definitions for the PRBS31 receive checker: register map, lock FSM
// states and the sequence/statistics helper functions.
package prbs_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_BEAT   = 3'd2;
  localparam logic [2:0] REG_ERR    = 3'd3;
  localparam logic [2:0] REG_FRAME  = 3'd4;
  localparam logic [2:0] REG_LOL    = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // s[i] is the i-th bit in time order; word bit 31 is the earliest bit.
  function automatic logic [31:0] prbs31_next32(input logic [31:0] prev);
    logic [63:0] s;
    logic [31:0] nxt;
    s   = 64'd0;
    nxt = 32'd0;
    for (int i = 0; i < 32; i++) s[i] = prev[31-i];
    for (int i = 32; i < 64; i++) s[i] = s[i-31] ^ s[i-28];
    for (int j = 0; j < 32; j++) nxt[31-j] = s[32+j];
    return nxt;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) cnt = cnt + {5'd0, v[i]};
    return cnt;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/prbs_rx_checker_if.sv
// Bundle of the checker's AXI-Stream input and AXI4-Lite control port.
interface prbs_rx_checker_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic                            s_axis_tvalid;
  logic                            s_axis_tready;
  logic                            s_axis_sof;
  logic [31:0]                     s_axis_tdata;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [2:0]                      s_axi_awprot;
  logic                            s_axi_awvalid;
  logic                            s_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                            s_axi_wvalid;
  logic                            s_axi_wready;
  logic [1:0]                      s_axi_bresp;
  logic                            s_axi_bvalid;
  logic                            s_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [2:0]                      s_axi_arprot;
  logic                            s_axi_arvalid;
  logic                            s_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                      s_axi_rresp;
  logic                            s_axi_rvalid;
  logic                            s_axi_rready;

  modport slave (
    input  s_axis_tvalid, s_axis_sof, s_axis_tdata,
    output s_axis_tready,
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axis_tvalid, s_axis_sof, s_axis_tdata,
    input  s_axis_tready,
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/prbs_rx_regs.sv
// AXI4-Lite slave for the checker: CTRL register, CLEAR pulse and status read mux.
module prbs_rx_regs
  import prbs_pkg::*;
(
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  prbs_rx_checker_if.slave  bus,
  output logic              ctrl_enable_r,
  output logic              clear_s,
  input  logic [31:0]       status_s,
  input  logic [31:0]       beat_cnt_r,
  input  logic [31:0]       err_bits_r,
  input  logic [31:0]       frame_cnt_r,
  input  logic [31:0]       lol_cnt_r
);
  logic        awready_r, bvalid_r, arready_r, rvalid_r;
  logic        wr_fire_s, rd_fire_s, unused_s;
  logic [31:0] rdata_r, rd_mux_s;

  assign wr_fire_s = awready_r & bus.s_axi_awvalid & bus.s_axi_wvalid;
  assign rd_fire_s = arready_r & bus.s_axi_arvalid;
  assign clear_s   = wr_fire_s & (bus.s_axi_awaddr[4:2] == REG_CTRL) & bus.s_axi_wdata[1];
  assign unused_s  = ^{bus.s_axi_awaddr[31:5], bus.s_axi_awaddr[1:0], bus.s_axi_araddr[31:5],
                       bus.s_axi_araddr[1:0], bus.s_axi_wdata[31:2], bus.s_axi_wstrb,
                       bus.s_axi_awprot, bus.s_axi_arprot};

  assign bus.s_axi_awready = awready_r;
  assign bus.s_axi_wready  = awready_r;
  assign bus.s_axi_bvalid  = bvalid_r;
  assign bus.s_axi_bresp   = 2'b00;
  assign bus.s_axi_arready = arready_r;
  assign bus.s_axi_rvalid  = rvalid_r;
  assign bus.s_axi_rdata   = rdata_r;
  assign bus.s_axi_rresp   = 2'b00;

  // Write channel: joint aw/w acceptance, response hold, CTRL register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_r     <= 1'b0;
      bvalid_r      <= 1'b0;
      ctrl_enable_r <= 1'b0;
    end else begin
      awready_r <= bus.s_axi_awvalid & bus.s_axi_wvalid & ~awready_r & ~bvalid_r;
      if (wr_fire_s) bvalid_r <= 1'b1;
      else if (bus.s_axi_bready) bvalid_r <= 1'b0;
      if (wr_fire_s && (bus.s_axi_awaddr[4:2] == REG_CTRL)) ctrl_enable_r <= bus.s_axi_wdata[0];
    end
  end

  // Read address decode; offsets beyond the map read as zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (bus.s_axi_araddr[4:2])
      REG_CTRL:   rd_mux_s = {31'd0, ctrl_enable_r};
      REG_STATUS: rd_mux_s = status_s;
      REG_BEAT:   rd_mux_s = beat_cnt_r;
      REG_ERR:    rd_mux_s = err_bits_r;
      REG_FRAME:  rd_mux_s = frame_cnt_r;
      REG_LOL:    rd_mux_s = lol_cnt_r;
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Read channel: one-cycle arready, data captured at acceptance and held until taken.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      arready_r <= bus.s_axi_arvalid & ~rvalid_r & ~arready_r;
      if (rd_fire_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_mux_s;
      end else if (bus.s_axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/prbs_rx_checker.sv
// PRBS31 receive checker: SOF-seeded lock, two-stage compare pipeline,
// saturating error statistics and a lock-loss detector.
module prbs_rx_checker
  import prbs_pkg::*;
#(
  parameter int LOSS_THRESH = 4
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  prbs_rx_checker_if.slave bus
);
  rx_state_e   state_r, state_nxt_s;
  logic        ctrl_enable_r, clear_s, tready_r, acc_s;
  logic        locked_s, seed_s, check_s;
  logic        chk_r, sof_r, chk2_s, err_s, lol_s, err_seen_r;
  logic [3:0]  consec_r;
  logic [31:0] exp_r, diff_r, status_s;
  logic [31:0] beat_cnt_r, err_bits_r, frame_cnt_r, lol_cnt_r;

  prbs_rx_regs u_regs (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .bus           (bus),
    .ctrl_enable_r (ctrl_enable_r),
    .clear_s       (clear_s),
    .status_s      (status_s),
    .beat_cnt_r    (beat_cnt_r),
    .err_bits_r    (err_bits_r),
    .frame_cnt_r   (frame_cnt_r),
    .lol_cnt_r     (lol_cnt_r)
  );

  assign bus.s_axis_tready = tready_r;
  assign acc_s    = bus.s_axis_tvalid & tready_r;
  assign status_s = {30'd0, err_seen_r, locked_s};
  // A beat still in flight when lock drops is discarded at stage 2.
  assign chk2_s   = chk_r & (state_r == LOCKED);
  assign err_s    = chk2_s & (diff_r != 32'd0);
  assign lol_s    = err_s & (({1'b0, consec_r} + 5'd1) >= 5'(LOSS_THRESH));

  // Stream ready follows the enable bit one cycle later.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) tready_r <= 1'b0;
    else                tready_r <= ctrl_enable_r;
  end

  // Lock FSM state register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_r <= IDLE;
    else                state_r <= state_nxt_s;
  end

  // Lock FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (!ctrl_enable_r) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = HUNT;
        HUNT:    state_nxt_s = seed_s ? LOCKED : HUNT;
        LOCKED:  state_nxt_s = lol_s ? HUNT : LOCKED;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Lock FSM outputs: seeding in HUNT, checking in LOCKED.
  always_comb begin
    locked_s = 1'b0;
    seed_s   = 1'b0;
    check_s  = 1'b0;
    case (state_r)
      HUNT:    seed_s = acc_s & bus.s_axis_sof;
      LOCKED: begin
        locked_s = 1'b1;
        check_s  = acc_s;
      end
      default: begin
        locked_s = 1'b0;
        seed_s   = 1'b0;
        check_s  = 1'b0;
      end
    endcase
  end

  // Expected-word generator; advances from the prediction so a bit error is counted once.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)    exp_r <= 32'd0;
    else if (!ctrl_enable_r) exp_r <= 32'd0;
    else if (seed_s)       exp_r <= prbs31_next32(bus.s_axis_tdata);
    else if (check_s)      exp_r <= prbs31_next32(exp_r);
  end

  // Stage 1: registered difference against the expected word.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      diff_r <= 32'd0;
      chk_r  <= 1'b0;
      sof_r  <= 1'b0;
    end else begin
      diff_r <= bus.s_axis_tdata ^ exp_r;
      chk_r  <= check_s;
      sof_r  <= acc_s & bus.s_axis_sof & ctrl_enable_r;
    end
  end

  // Stage 2: statistics, sticky error flag and consecutive-error tracking; CLEAR wins.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      beat_cnt_r  <= 32'd0;
      err_bits_r  <= 32'd0;
      frame_cnt_r <= 32'd0;
      lol_cnt_r   <= 32'd0;
      err_seen_r  <= 1'b0;
      consec_r    <= 4'd0;
    end else if (clear_s) begin
      beat_cnt_r  <= 32'd0;
      err_bits_r  <= 32'd0;
      frame_cnt_r <= 32'd0;
      lol_cnt_r   <= 32'd0;
      err_seen_r  <= 1'b0;
      consec_r    <= 4'd0;
    end else begin
      if (chk2_s) beat_cnt_r <= sat_add32(beat_cnt_r, 32'd1);
      if (chk2_s) err_bits_r <= sat_add32(err_bits_r, {26'd0, popcount32(diff_r)});
      if (sof_r)  frame_cnt_r <= sat_add32(frame_cnt_r, 32'd1);
      if (lol_s)  lol_cnt_r <= sat_add32(lol_cnt_r, 32'd1);
      if (err_s)  err_seen_r <= 1'b1;
      if (lol_s)       consec_r <= 4'd0;
      else if (chk2_s) consec_r <= err_s ? (consec_r + 4'd1) : 4'd0;
    end
  end
endmodule

// File: tb/tb_prbs_rx_checker.sv
// Directed bench for prbs_rx_checker: hand-computed PRBS31 words, register
// reads after each scenario, clear/reset behaviour.
module tb_prbs_rx_checker;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  prbs_rx_checker_if bus_if ();

  prbs_rx_checker #(.LOSS_THRESH(4)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .bus           (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    bit done = 1'b0;
    bus_if.s_axi_awaddr  = addr;
    bus_if.s_axi_wdata   = data;
    bus_if.s_axi_awvalid = 1'b1;
    bus_if.s_axi_wvalid  = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus_if.s_axi_awready;
      step();
    end
    bus_if.s_axi_awvalid = 1'b0;
    bus_if.s_axi_wvalid  = 1'b0;
    check("aw_handshake", {31'd0, done}, 32'd1);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bit done = 1'b0;
    bit got  = 1'b0;
    bus_if.s_axi_araddr  = addr;
    bus_if.s_axi_arvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus_if.s_axi_arready;
      step();
    end
    bus_if.s_axi_arvalid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus_if.s_axi_rvalid) got = 1'b1;
      else step();
    end
    check({tag, "_rvalid"}, {31'd0, got}, 32'd1);
    check(tag, bus_if.s_axi_rdata, exp);
  endtask

  task automatic send_beat(input logic sof, input logic [31:0] data);
    bit took = 1'b0;
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_sof    = sof;
    bus_if.s_axis_tdata  = data;
    for (int i = 0; i < 20 && !took; i++) begin
      took = bus_if.s_axis_tready;
      step();
    end
    check("beat_accept", {31'd0, took}, 32'd1);
  endtask

  task automatic idle(input int n);
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_sof    = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_sof    = 1'b0;
    bus_if.s_axis_tdata  = 32'd0;
    bus_if.s_axi_awaddr  = 32'd0;
    bus_if.s_axi_awprot  = 3'd0;
    bus_if.s_axi_awvalid = 1'b0;
    bus_if.s_axi_wdata   = 32'd0;
    bus_if.s_axi_wstrb   = 4'hF;
    bus_if.s_axi_wvalid  = 1'b0;
    bus_if.s_axi_bready  = 1'b1;
    bus_if.s_axi_araddr  = 32'd0;
    bus_if.s_axi_arprot  = 3'd0;
    bus_if.s_axi_arvalid = 1'b0;
    bus_if.s_axi_rready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready",  {31'd0, bus_if.s_axis_tready}, 32'd0);
    check("rst_awready", {31'd0, bus_if.s_axi_awready}, 32'd0);
    check("rst_arready", {31'd0, bus_if.s_axi_arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bus_if.s_axi_bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, bus_if.s_axi_rvalid},  32'd0);
    check("rst_rdata",   bus_if.s_axi_rdata, 32'd0);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 6; a++) read_check("reset_reg", 32'(a * 4), 32'd0);

    // Enable: ready rises one cycle after the write response appears.
    axi_write(32'h00, 32'h1);
    check("bvalid_after_wr", {31'd0, bus_if.s_axi_bvalid}, 32'd1);
    check("tready_with_bvalid", {31'd0, bus_if.s_axis_tready}, 32'd0);
    step();
    check("tready_rise", {31'd0, bus_if.s_axis_tready}, 32'd1);

    // Lock on all-ones SOF; the next word of the sequence is 0x0000000E.
    send_beat(1'b1, 32'hFFFF_FFFF);
    send_beat(1'b0, 32'h0000_000E);
    idle(3);
    read_check("lock_status", 32'h04, 32'd1);
    read_check("lock_beats",  32'h08, 32'd1);
    read_check("lock_errs",   32'h0C, 32'd0);
    read_check("lock_frames", 32'h10, 32'd1);

    // Restart from IDLE with counters cleared; one flipped bit, then clean words.
    axi_write(32'h00, 32'h0);
    axi_write(32'h00, 32'h3);
    send_beat(1'b1, 32'hFFFF_FFFF);
    send_beat(1'b0, 32'h0000_000F);
    send_beat(1'b0, 32'h0000_00FC);
    send_beat(1'b0, 32'h0000_0E38);
    idle(3);
    read_check("err_status", 32'h04, 32'd3);
    read_check("err_bits",   32'h0C, 32'd1);
    read_check("err_beats",  32'h08, 32'd3);
    read_check("err_frames", 32'h10, 32'd1);
    read_check("err_lol",    32'h14, 32'd0);

    // Four consecutive errored beats drop lock.
    for (int k = 0; k < 4; k++) send_beat(1'b0, 32'hFFFF_FFFF);
    idle(3);
    read_check("lol_status", 32'h04, 32'd2);
    read_check("lol_count",  32'h14, 32'd1);
    read_check("lol_beats",  32'h08, 32'd7);

    // Relock on the next SOF.
    send_beat(1'b1, 32'hFFFF_FFFF);
    send_beat(1'b0, 32'h0000_000E);
    idle(3);
    read_check("relock_status", 32'h04, 32'd3);
    read_check("relock_beats",  32'h08, 32'd8);
    read_check("relock_frames", 32'h10, 32'd2);
    read_check("unmapped_18",   32'h18, 32'd0);

    // CLEAR lands on the stage-2 update of the last back-to-back beat.
    fork
      begin
        send_beat(1'b0, 32'h0000_00FC);
        send_beat(1'b0, 32'h0000_0E38);
        send_beat(1'b0, 32'h0000_FFF0);
        send_beat(1'b0, 32'h000E_00E0);
        idle(1);
      end
      begin
        repeat (3) step();
        axi_write(32'h00, 32'h3);
      end
    join
    idle(3);
    read_check("clr_beats",  32'h08, 32'd0);
    read_check("clr_errs",   32'h0C, 32'd0);
    read_check("clr_frames", 32'h10, 32'd0);
    read_check("clr_lol",    32'h14, 32'd0);
    read_check("clr_status", 32'h04, 32'd1);

    // Disable: back to IDLE with ready low.
    axi_write(32'h00, 32'h0);
    step();
    check("dis_tready", {31'd0, bus_if.s_axis_tready}, 32'd0);
    read_check("dis_status", 32'h04, 32'd0);
    read_check("dis_ctrl",   32'h00, 32'd0);

    // Asynchronous reset in the middle of a stream.
    axi_write(32'h00, 32'h1);
    send_beat(1'b1, 32'hFFFF_FFFF);
    send_beat(1'b0, 32'h0000_000E);
    idle(3);
    read_check("pre_rst_status", 32'h04, 32'd1);
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tdata  = 32'h0000_00FC;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tready",  {31'd0, bus_if.s_axis_tready}, 32'd0);
    check("mid_rst_awready", {31'd0, bus_if.s_axi_awready}, 32'd0);
    check("mid_rst_bvalid",  {31'd0, bus_if.s_axi_bvalid},  32'd0);
    check("mid_rst_rvalid",  {31'd0, bus_if.s_axi_rvalid},  32'd0);
    check("mid_rst_rdata",   bus_if.s_axi_rdata, 32'd0);
    idle(2);
    rst_n = 1'b1;
    step();
    read_check("post_rst_status", 32'h04, 32'd0);
    read_check("post_rst_beats",  32'h08, 32'd0);
    read_check("post_rst_frames", 32'h10, 32'd0);
    read_check("post_rst_ctrl",   32'h00, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prbs_rx_checker.md
# prbs_rx_checker

PRBS31 receive checker, the far end of the PRBS transmitter's AXI-Stream output. It consumes 32-bit beats with a start-of-frame flag and self-synchronises on a SOF beat. It then compares every following beat against the predicted sequence and accumulates beat, frame, bit-error and loss-of-lock statistics. Control and status are exposed on an AXI4-Lite slave hung off a master port of the AXI interconnect.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width; decode uses addr[4:2]
- LOSS_THRESH, 4, consecutive errored beats that drop lock (1..15)
- s_axi_aclk  in  1  single clock for all logic
- s_axi_aresetn  in  1  reset, asynchronous, active-low
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready
- s_axis_sof  in  1  beat is first of a frame
- s_axis_tdata  in  32  PRBS data; tdata[31] earliest bit
- s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave, standard widths (awaddr/araddr 32, awprot/arprot 3, wstrb 4, bresp/rresp 2, wdata/rdata 32)

## Operation
- Sequence: b[n] = b[n-31] xor b[n-28]; each beat carries 32 consecutive bits, tdata[31] first.
- Registers (byte offsets):
  - 0x00 CTRL RW: bit0 ENABLE; bit1 CLEAR (write-1 pulse, reads 0).
  - 0x04 STATUS RO: bit0 LOCKED; bit1 ERR_SEEN (sticky until CLEAR).
  - 0x08 BEAT_CNT: beats checked.
  - 0x0C ERR_BITS: sum of popcount(rx xor expected).
  - 0x10 FRAME_CNT: SOF beats accepted while enabled.
  - 0x14 LOL_CNT: LOCKED->HUNT transitions.
  - All counters are 32-bit and saturate at 0xFFFFFFFF. Unmapped reads return 0. wstrb is ignored.
- FSM states: IDLE, HUNT, LOCKED.
  - IDLE -> HUNT when ENABLE=1.
  - Any state -> IDLE when ENABLE=0; the LFSR is cleared.
  - HUNT: non-SOF beats are discarded. A SOF beat seeds the expected state from the received 32 bits, moves to LOCKED, and is not checked; FRAME_CNT still increments.
  - LOCKED: every beat, SOF or not, is checked against the expected word. The expected state always advances from the predicted word, never the received one, so one flipped bit counts once.
  - LOCKED -> HUNT after LOSS_THRESH consecutive beats with nonzero error; LOL_CNT increments. A clean beat resets the consecutive count.
- CLEAR zeroes all counters, ERR_SEEN and the consecutive count. It does not change the FSM state. If CLEAR coincides with a counted beat, the clear wins.
- s_axis_tready = registered ENABLE; 0 in reset and while disabled.

## Timing
- Reset values: s_axis_tready=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=00, rdata=0. All registers are 0 and the FSM is in IDLE.
- Stream pipeline:
  - Accept cycle N.
  - Stage 1 (N+1): registered xor against expected.
  - Stage 2 (N+2): popcount is added and counters, STATUS and the FSM lock-loss decision update.
  - A read issued at N+2 or later sees beat N.
- Full rate: one beat per cycle with no bubbles. FSM transitions on a beat take effect for beat N+1.
- AXI-Lite write:
  - awready and wready pulse together for one cycle once both awvalid and wvalid are high.
  - bvalid is asserted the next cycle and held until bready.
  - No new write is accepted while bvalid=1.
  - A CTRL write affects s_axis_tready 1 cycle after the write is accepted.
- AXI-Lite read:
  - arready pulses for one cycle when arvalid=1 and rvalid=0.
  - rvalid and rdata follow the next cycle and are held until rready.
- Responses are always OKAY.
- Asynchronous reset mid-frame returns the block to IDLE immediately. Partial pipeline contents are discarded.

## Structure
- Package prbs_pkg:
  - register offset localparams;
  - FSM enum {IDLE, HUNT, LOCKED};
  - function prbs31_next32(logic [31:0] prev) returning the next 32-bit word;
  - function popcount32.
- Sub-module prbs_rx_regs: AXI-Lite slave, CTRL register, CLEAR pulse and read mux. The checker core, counters and FSM stay in the top module.

## Test plan
- Reset, then read 0x00–0x14: all 0. After ENABLE=1, s_axis_tready rises 1 cycle after bvalid.
- With ENABLE=1, send SOF 0xFFFFFFFF then 0x0000000E: LOCKED=1, BEAT_CNT=1, ERR_BITS=0, FRAME_CNT=1.
- Same as previous, but the second beat is 0x0000000F: ERR_BITS=1, ERR_SEEN=1. Continue with a correct sequence: LOCKED stays 1.
- While LOCKED, send 4 beats of 0xFFFFFFFF without SOF: LOCKED=0 and LOL_CNT=1. The next SOF beat relocks.
- Write CLEAR during back-to-back beats: all counters read 0 afterwards and LOCKED is unchanged. Then write ENABLE=0: state is IDLE and s_axis_tready=0.
- Assert s_axi_aresetn low mid-stream: all outputs return to their reset values, and LOCKED=0 after release.
